// File: rtl/smpc_pad_reader_pkg.sv
// rtl/smpc_pad_reader_pkg.sv - FSM states, peripheral constants and pin helpers for the pad reader
package smpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_WAIT,
        ST_SAMP,
        ST_EMIT,
        ST_FIN
    } PadState_t;

    localparam logic [2:0] PAD_ID_STD  = 3'b100;
    localparam logic [7:0] PST_DIRECT1 = 8'hF1;
    localparam logic [7:0] PST_NONE    = 8'hF0;
    localparam logic [7:0] PAD_DEVID   = 8'h02;
    localparam logic [6:0] PIN_IDLE    = 7'h60;

    // {TH,TR} follows the phase number; TL and the data pins are never driven high
    function automatic logic [6:0] phase_drive(input logic [1:0] ph);
        return {ph, 5'b0_0000};
    endfunction

endpackage

// File: rtl/smpc_pad_reader_if.sv
// rtl/smpc_pad_reader_if.sv - peripheral byte stream from the pad reader to the SMPC OREG writer
interface smpc_pad_reader_if;
    logic [7:0] BYTE_DATA;
    logic       BYTE_VALID;
    logic       BYTE_READY;

    modport master (output BYTE_DATA, output BYTE_VALID, input BYTE_READY);
    modport slave  (input BYTE_DATA, input BYTE_VALID, output BYTE_READY);
endinterface

// File: rtl/smpc_pad_reader_sync.sv
// rtl/smpc_pad_reader_sync.sv - 2-flop pin synchronizer, built only when SMPC_PAD_SYNC_EN is defined
`ifdef SMPC_PAD_SYNC_EN
module smpc_pad_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule
`endif

// File: rtl/smpc_pad_reader.sv
// rtl/smpc_pad_reader.sv - 4-phase standard-pad scanner for ports 1/2 feeding INTBACK peripheral bytes
// Define SMPC_PAD_SYNC_EN to sample P1I/P2I through a 2-flop synchronizer instead of directly.
module smpc_pad_reader
    import smpc_pkg::*;
#(
    parameter int SETTLE = 8,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CE,
    input  logic              START,
    input  logic [1:0]        PORT_EN,
    input  logic [6:0]        P1I,
    output logic [6:0]        P1O,
    input  logic [6:0]        P2I,
    output logic [6:0]        P2O,
    smpc_pad_reader_if.master byte_if,
    output logic              BUSY,
    output logic              DONE
);
    PadState_t        state_q, state_d;
    logic [1:0]       ph_q, ph_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             port_q, port_d;
    logic             en2_q, en2_d;
    logic [1:0]       bidx_q, bidx_d;
    logic [3:0][3:0]  nib_q, nib_d;
    logic [6:0]       p1o_q, p1o_d;
    logic [6:0]       p2o_q, p2o_d;
    logic [7:0]       pins_s;
    logic             is_pad;
    logic [1:0]       last_idx;
    logic             unused_pins;

    assign unused_pins = ^{P1I[6:4], P2I[6:4]};

`ifdef SMPC_PAD_SYNC_EN
    smpc_pad_sync #(.W(8)) u_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     ({P2I[3:0], P1I[3:0]}),
        .q     (pins_s)
    );
`else
    assign pins_s = {P2I[3:0], P1I[3:0]};
`endif

    assign is_pad   = (nib_q[3][2:0] == PAD_ID_STD);
    assign last_idx = is_pad ? 2'd3 : 2'd0;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        en2_d   = en2_q;
        bidx_d  = bidx_q;
        nib_d   = nib_q;
        p1o_d   = p1o_q;
        p2o_d   = p2o_q;
        case (state_q)
            ST_IDLE: begin
                // START is a single-CLK pulse, so it is taken even on a non-CE cycle
                if (START) begin
                    en2_d   = PORT_EN[1];
                    port_d  = ~PORT_EN[0];
                    ph_d    = 2'd0;
                    state_d = (PORT_EN == 2'b00) ? ST_FIN : ST_SEL;
                end
            end
            ST_SEL: begin
                if (CE) begin
                    p1o_d   = port_q ? PIN_IDLE : phase_drive(ph_q);
                    p2o_d   = port_q ? phase_drive(ph_q) : PIN_IDLE;
                    cnt_d   = CNT_W'(SETTLE);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (CE) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = ST_SAMP;
                end
            end
            ST_SAMP: begin
                if (CE) begin
                    nib_d[ph_q] = port_q ? pins_s[7:4] : pins_s[3:0];
                    ph_d        = ph_q + 2'd1;
                    bidx_d      = 2'd0;
                    state_d     = (ph_q == 2'd3) ? ST_EMIT : ST_SEL;
                end
            end
            ST_EMIT: begin
                // the byte handshake runs at full CLK rate regardless of CE
                if (byte_if.BYTE_READY) begin
                    if (bidx_q == last_idx) begin
                        if (!port_q && en2_q) begin
                            port_d  = 1'b1;
                            state_d = ST_SEL;
                        end else begin
                            state_d = ST_FIN;
                        end
                    end else begin
                        bidx_d = bidx_q + 2'd1;
                    end
                end
            end
            ST_FIN: begin
                p1o_d   = PIN_IDLE;
                p2o_d   = PIN_IDLE;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            ph_q    <= 2'd0;
            cnt_q   <= '0;
            port_q  <= 1'b0;
            en2_q   <= 1'b0;
            bidx_q  <= 2'd0;
            nib_q   <= '0;
            p1o_q   <= PIN_IDLE;
            p2o_q   <= PIN_IDLE;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            en2_q   <= en2_d;
            bidx_q  <= bidx_d;
            nib_q   <= nib_d;
            p1o_q   <= p1o_d;
            p2o_q   <= p2o_d;
        end
    end

    always_comb begin
        byte_if.BYTE_VALID = (state_q == ST_EMIT);
        byte_if.BYTE_DATA  = 8'h00;
        if (state_q == ST_EMIT) begin
            case (bidx_q)
                2'd0:    byte_if.BYTE_DATA = is_pad ? PST_DIRECT1 : PST_NONE;
                2'd1:    byte_if.BYTE_DATA = PAD_DEVID;
                2'd2:    byte_if.BYTE_DATA = {nib_q[2], nib_q[1]};
                default: byte_if.BYTE_DATA = {nib_q[0], nib_q[3]};
            endcase
        end
    end

    assign P1O  = p1o_q;
    assign P2O  = p2o_q;
    assign BUSY = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign DONE = (state_q == ST_FIN);

endmodule

// File: tb/tb_smpc_pad_reader.sv
// tb/tb_smpc_pad_reader.sv - randomized scoreboard bench for smpc_pad_reader with a behavioural pad model
module tb_smpc_pad_reader;
    localparam int S = 3;

    logic       CLK;
    logic       RST_N;
    logic       CE;
    logic       START;
    logic [1:0] PORT_EN;
    logic [6:0] P1I, P1O, P2I, P2O;
    logic       BUSY, DONE;

    smpc_pad_reader_if bif();

    smpc_pad_reader #(.SETTLE(S), .CNT_W(8)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .CE      (CE),
        .START   (START),
        .PORT_EN (PORT_EN),
        .P1I     (P1I),
        .P1O     (P1O),
        .P2I     (P2I),
        .P2O     (P2O),
        .byte_if (bif),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [3:0] pad_nib [2][4];
    bit         done_armed = 0;
    int         done_seen  = 0;
    int         stall02_cnt = 0;
    int         ce_mode = 0;
    bit         rand_ready = 0;
    bit         bp_arm = 0;
    int         stall_left = 0;
    int         cyc = 0;
    logic       ce_edge;
    logic       prev_stall;
    logic       prev_busy;
    logic [7:0] prev_data;
    logic [13:0] prev_pins;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // A standard pad answers each {TH,TR} select with the nibble for that phase
    always_comb begin
        P1I = {P1O[6:4], pad_nib[0][P1O[6:5]]};
        P2I = {P2O[6:4], pad_nib[1][P2O[6:5]]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_expect(input int p);
        logic [3:0] n0, n1, n2, n3;
        n0 = pad_nib[p][0];
        n1 = pad_nib[p][1];
        n2 = pad_nib[p][2];
        n3 = pad_nib[p][3];
        if (n3[2:0] == 3'b100) begin
            exp_q.push_back(8'hF1);
            exp_q.push_back(8'h02);
            exp_q.push_back({n2, n1});
            exp_q.push_back({n0, n3});
        end else begin
            exp_q.push_back(8'hF0);
        end
    endfunction

    task automatic rand_pad(input int p, input bit pad);
        for (int i = 0; i < 3; i++) pad_nib[p][i] = 4'($urandom);
        pad_nib[p][3] = pad ? {1'($urandom), 3'b100} : {1'($urandom), 3'($urandom)};
    endtask

    task automatic pulse_start(input logic [1:0] en);
        @(negedge CLK);
        PORT_EN = en;
        START   = 1'b1;
        @(posedge CLK);
        #1;
        START   = 1'b0;
        PORT_EN = 2'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int start_cnt;
        int c;
        start_cnt = done_seen;
        c = 0;
        while (done_seen == start_cnt && c < budget) begin
            @(posedge CLK);
            c++;
        end
        check("done_seen", done_seen - start_cnt, 1);
        done_armed = 0;
    endtask

    task automatic run_scan(input logic [1:0] en, input bit chk_lat);
        int lat;
        if (en[0]) push_expect(0);
        if (en[1]) push_expect(1);
        done_armed = 1;
        pulse_start(en);
        if (en == 2'b00) begin
            check("zero_en_done_next_clk", DONE, 1);
        end else begin
            check("busy_after_start", BUSY, 1);
            if (chk_lat) begin
                lat = 0;
                while (!bif.BYTE_VALID && lat < 1000) begin
                    @(posedge CLK);
                    #1;
                    lat++;
                end
                check("first_byte_latency", lat, 4 * (S + 2));
            end
        end
        wait_done(20000);
    endtask

    always @(posedge CLK) ce_edge <= CE;

    initial begin
        CE = 1'b1;
        forever begin
            @(negedge CLK);
            cyc++;
            case (ce_mode)
                1:       CE = (cyc % 4 == 0);
                2:       CE = 1'($urandom);
                default: CE = 1'b1;
            endcase
        end
    end

    initial begin
        bif.BYTE_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #2;
            if (stall_left > 0) begin
                bif.BYTE_READY = 1'b0;
                stall_left--;
            end else if (bp_arm && bif.BYTE_VALID && bif.BYTE_DATA == 8'h02) begin
                bp_arm = 0;
                stall_left = 4;
                bif.BYTE_READY = 1'b0;
            end else begin
                bif.BYTE_READY = rand_ready ? 1'($urandom) : 1'b1;
            end
        end
    end

    // Scoreboard monitor: pops one expected byte per accepted transfer
    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_stall <= 1'b0;
            prev_busy  <= 1'b0;
            prev_pins  <= {7'h60, 7'h60};
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(bif.BYTE_VALID), 1);
                check("hold_data", 32'(bif.BYTE_DATA), 32'(prev_data));
            end
            if (prev_busy && {P1O, P2O} != prev_pins) begin
                check("pin_change_on_ce", 32'(ce_edge), 1);
                check("one_port_driven", 32'(P1O == 7'h60 || P2O == 7'h60), 1);
            end
            if (bif.BYTE_VALID && !bif.BYTE_READY && bif.BYTE_DATA == 8'h02) stall02_cnt <= stall02_cnt + 1;
            if (bif.BYTE_VALID && bif.BYTE_READY) begin
                check("byte_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("byte_data", 32'(bif.BYTE_DATA), 32'(exp_q.pop_front()));
            end
            if (DONE) begin
                check("done_expected", 32'(done_armed), 1);
                check("bytes_left_at_done", exp_q.size(), 0);
                done_seen <= done_seen + 1;
            end
            prev_stall <= bif.BYTE_VALID && !bif.BYTE_READY;
            prev_data  <= bif.BYTE_DATA;
            prev_busy  <= BUSY;
            prev_pins  <= {P1O, P2O};
        end
    end

    initial begin
        int c;
        int st0;
        RST_N   = 1'b0;
        START   = 1'b0;
        PORT_EN = 2'b00;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 4; i++) pad_nib[p][i] = 4'hF;
        #12;
        check("rst_p1o", P1O, 7'h60);
        check("rst_p2o", P2O, 7'h60);
        check("rst_data", bif.BYTE_DATA, 0);
        check("rst_valid", bif.BYTE_VALID, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        @(negedge CLK);
        #1 RST_N = 1'b1;

        // port1 pad, all buttons released
        pad_nib[0][3] = 4'hC;
        run_scan(2'b01, 1);
        @(negedge CLK);
        check("p1o_idle_after_scan", P1O, 7'h60);

        // A and Up pressed on port1, port2 reports no pad
        pad_nib[0][0] = 4'hF; pad_nib[0][1] = 4'hB; pad_nib[0][2] = 4'hE; pad_nib[0][3] = 4'hC;
        for (int i = 0; i < 4; i++) pad_nib[1][i] = 4'hF;
        run_scan(2'b11, 1);

        // backpressure on the device-id byte
        st0 = stall02_cnt;
        bp_arm = 1;
        run_scan(2'b01, 1);
        check("stall_cycles_on_02", stall02_cnt - st0, 5);

        // START while busy is ignored, then START with no ports enabled
        rand_pad(0, 1);
        push_expect(0);
        done_armed = 1;
        pulse_start(2'b01);
        repeat (6) @(posedge CLK);
        pulse_start(2'b11);
        wait_done(2000);
        run_scan(2'b00, 0);

        // asynchronous reset while port2 is settling
        rand_pad(0, 1);
        rand_pad(1, 1);
        push_expect(0);
        pulse_start(2'b11);
        c = 0;
        while (P2O == 7'h60 && c < 500) begin
            @(posedge CLK);
            #1;
            c++;
        end
        check("port2_scan_started", 32'(P2O != 7'h60), 1);
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        check("arst_p1o", P1O, 7'h60);
        check("arst_p2o", P2O, 7'h60);
        check("arst_data", bif.BYTE_DATA, 0);
        check("arst_valid", bif.BYTE_VALID, 0);
        check("arst_busy", BUSY, 0);
        check("arst_done", DONE, 0);
        check("port1_bytes_all_taken", exp_q.size(), 0);
        exp_q.delete();
        @(negedge CLK);
        #1 RST_N = 1'b1;
        run_scan(2'b11, 1);

        // slow CE, same pads as a full-rate run
        rand_pad(0, 1);
        rand_pad(1, 0);
        run_scan(2'b11, 1);
        ce_mode = 1;
        run_scan(2'b11, 0);
        ce_mode = 0;

        for (int it = 0; it < 10; it++) begin
            rand_pad(0, 1'($urandom));
            rand_pad(1, 1'($urandom));
            ce_mode    = $urandom_range(0, 2);
            rand_ready = 1'($urandom);
            run_scan(2'($urandom), ce_mode == 0);
        end
        ce_mode    = 0;
        rand_ready = 0;
        repeat (4) @(posedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
